// File: rtl/median_pkg.sv
// Shared types and window-geometry constants for the 5x5 median sequencer.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } median_ctrl_state_e;

    localparam int WIN_DIM     = 5;
    localparam int WIN_N       = WIN_DIM * WIN_DIM;
    localparam int LB_ROWS     = WIN_DIM - 1;
    localparam int WIN_NEW_COL = WIN_DIM - 1;

    // Flat element index of window position (r,c) inside o_win.
    function automatic int win_idx(input int r, input int c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/median_line_buffer.sv
// Four cascaded line buffers sharing one column address; a write shifts the
// column down the cascade after the old values have been read.
module median_line_buffer
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int AW    = 6
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [AW-1:0]              i_addr,
    input  logic [WIDTH-1:0]           i_din,
    output logic [LB_ROWS*WIDTH-1:0]   o_rd
);

    logic [WIDTH-1:0] mem [LB_ROWS][IMG_W];

    genvar gi;
    generate
        for (gi = 0; gi < LB_ROWS; gi++) begin : g_rd
            assign o_rd[gi*WIDTH +: WIDTH] = mem[gi][i_addr];
        end
    endgenerate

    // Contents are never reset: a frame's FILL phase rewrites every column first.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[0][i_addr] <= i_din;
            for (int i = 1; i < LB_ROWS; i++) begin
                mem[i][i_addr] <= mem[i-1][i_addr];
            end
        end
    end

endmodule

// File: rtl/median_5x5_ctrl.sv
// Raster-stream sequencer feeding a 5x5 median datapath and registering its result.
// Optional macro MEDIAN_CTRL_STATS_EN adds a saturating completed-frame counter.
module median_5x5_ctrl
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_pixel,
    output logic                     o_ready,
    output logic [WIN_N*WIDTH-1:0]   o_win,
    output logic                     o_enable_5x5,
    input  logic [WIDTH-1:0]         i_median,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_median,
    input  logic                     i_ready,
    output logic                     o_busy,
    output logic                     o_done
`ifdef MEDIAN_CTRL_STATS_EN
    ,
    output logic [15:0]              o_frame_cnt
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FILL = RW'(WIN_DIM - 2);
    localparam logic [CW-1:0] COL_FIRST_INT = CW'(WIN_DIM - 1);
    localparam logic [RW-1:0] ROW_FIRST_INT = RW'(WIN_DIM - 1);

    median_ctrl_state_e state_q, state_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [WIN_N*WIDTH-1:0]   win_q, win_shift;
    logic                     win_valid_q, win_valid_d;
    logic                     out_valid_q, out_valid_d;
    logic [WIDTH-1:0]         median_q, median_d;
    logic [LB_ROWS*WIDTH-1:0] lb_rd;
    logic [WIDTH-1:0]         new_col [WIN_DIM];
    logic                     out_adv, win_adv, accept, interior, done;

    assign out_adv  = !out_valid_q || i_ready;
    assign win_adv  = !win_valid_q || out_adv;
    assign o_ready  = ((state_q == FILL) || (state_q == RUN)) && win_adv;
    assign accept   = i_valid && o_ready;
    assign interior = (row_q >= ROW_FIRST_INT) && (col_q >= COL_FIRST_INT);

    median_line_buffer #(
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .AW    (CW)
    ) u_lb (
        .i_clk  (i_clk),
        .i_we   (accept),
        .i_addr (col_q),
        .i_din  (i_pixel),
        .o_rd   (lb_rd)
    );

    // Incoming column, oldest row at the top: lb3, lb2, lb1, lb0, live pixel.
    genvar gi, gj;
    generate
        for (gi = 0; gi < LB_ROWS; gi++) begin : g_newcol
            assign new_col[gi] = lb_rd[(LB_ROWS-1-gi)*WIDTH +: WIDTH];
        end
        assign new_col[WIN_DIM-1] = i_pixel;

        for (gi = 0; gi < WIN_DIM; gi++) begin : g_row
            for (gj = 0; gj < WIN_DIM; gj++) begin : g_col
                if (gj == WIN_NEW_COL) begin : g_new
                    assign win_shift[win_idx(gi, gj)*WIDTH +: WIDTH] = new_col[gi];
                end else begin : g_old
                    assign win_shift[win_idx(gi, gj)*WIDTH +: WIDTH] =
                        win_q[win_idx(gi, gj+1)*WIDTH +: WIDTH];
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE:  if (i_start) state_d = FILL;
            FILL:  if (accept && row_q == ROW_FILL && col_q == COL_LAST) state_d = RUN;
            RUN:   if (accept && row_q == ROW_LAST && col_q == COL_LAST) state_d = DRAIN;
            DRAIN: begin
                if (!win_valid_q && !out_valid_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == IDLE && i_start) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A non-interior accept can only happen once the old window has left.
    always_comb begin
        win_valid_d = win_valid_q;
        out_valid_d = out_valid_q;
        median_d    = median_q;
        if (accept) begin
            win_valid_d = interior;
        end else if (out_adv) begin
            win_valid_d = 1'b0;
        end
        if (out_adv) begin
            out_valid_d = win_valid_q;
            if (win_valid_q) median_d = i_median;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            median_q    <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            out_valid_q <= out_valid_d;
            median_q    <= median_d;
            if (accept) win_q <= win_shift;
        end
    end

    assign o_win        = win_q;
    assign o_enable_5x5 = win_valid_q;
    assign o_valid      = out_valid_q;
    assign o_median     = median_q;
    assign o_busy       = (state_q != IDLE);
    assign o_done       = done;

`ifdef MEDIAN_CTRL_STATS_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
        end else if (done && frame_cnt_q != 16'hFFFF) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule
